mc_controller: RTL and testbench

- Multicycle control FSM for the RV32I core variant that shares one memory port for instructions and data.
- Sequences PC, IR, register file, ALU and memory over 3–5 cycles per instruction.
- Stalls on a memory ready handshake.
- Emits the same ALUOp/ImmSrc encodings the existing ALU decoder and immediate extender consume.

---
 rtl/core_ctrl_pkg.sv | 52 +++++
 rtl/imm_src_dec.sv | 19 +
 rtl/mc_controller.sv | 174 +++++++++++++++++
 tb/tb_mc_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared control encodings for the RV32I cores: FSM states, opcodes and
// the mux/ALU select codes consumed by the datapath.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_PC,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_dec.sv
// Opcode to immediate-format decode, shared by the single- and multicycle cores.
module imm_src_dec
    import core_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] ImmSrc
);

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BR:   ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM sharing one memory port for fetch and data;
// stalls in FETCH/MEMREAD/MEMWRITE until mem_ready.
module mc_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned RESET_IDLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       funct3_0,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] idle_cnt_q, idle_cnt_d;
    logic       pc_update;
    logic       branch;

    imm_src_dec u_imm_src_dec (
        .op     (op),
        .ImmSrc (ImmSrc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_RESET;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;

        case (state_q)
            S_RESET: begin
                if (idle_cnt_q == IDLE_LAST) state_d = S_FETCH;
                else                         idle_cnt_d = idle_cnt_q + 4'd1;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                ResultSrc = RES_ALURESULT;
                ALUSrcB   = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // OldPC + imm lands in ALUOut for branch/jal targets
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUOp      = ALUOP_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JALR_PC;
            end
            S_JALR_PC: begin
                // rs1 already consumed into ALUOut, so rd==rs1 cannot corrupt the target
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        PCWrite = pc_update | (branch & (zero ^ funct3_0));
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic       funct3_0, zero, mem_ready;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic       instr_done, illegal_op;

    mc_controller #(.RESET_IDLE_CYCLES(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3_0   (funct3_0),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ImmSrc     (ImmSrc),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;

    typedef enum {T_RESET, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                  T_EXEC_R, T_EXEC_I, T_ALUWB, T_BRANCH, T_JAL, T_JALR, T_JALR_PC, T_TRAP} st_t;

    typedef struct packed {
        logic       mem_req, mw, adr, irw, pcw, rw;
        logic [1:0] rs, sa, sb, aop, imm;
        logic       done, ill;
    } outs_t;

    typedef struct {
        string nm;
        outs_t e;
    } item_t;

    item_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_step = 0;

    function automatic outs_t model(st_t st, logic rdy, logic z, logic f3, logic [6:0] o);
        outs_t e = '0;
        if (o == SW)       e.imm = 2'b01;
        else if (o == BR)  e.imm = 2'b10;
        else if (o == JAL) e.imm = 2'b11;
        case (st)
            T_FETCH:    begin e.mem_req = 1; e.rs = 2'b10; e.sb = 2'b10; e.irw = rdy; e.pcw = rdy; end
            T_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
            T_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
            T_MEMREAD:  begin e.mem_req = 1; e.adr = 1; end
            T_MEMWB:    begin e.rs = 2'b01; e.rw = 1; e.done = 1; end
            T_MEMWRITE: begin e.mem_req = 1; e.mw = 1; e.adr = 1; e.done = rdy; end
            T_EXEC_R:   begin e.sa = 2'b10; e.aop = 2'b10; end
            T_EXEC_I:   begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
            T_ALUWB:    begin e.rw = 1; e.done = 1; end
            T_BRANCH:   begin e.sa = 2'b10; e.aop = 2'b01; e.done = 1; e.pcw = z ^ f3; end
            T_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
            T_JALR:     begin e.sa = 2'b10; e.sb = 2'b01; end
            T_JALR_PC:  begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
            T_TRAP:     begin e.ill = 1; end
            default:    ;
        endcase
        return e;
    endfunction

    task automatic push(input st_t st);
        item_t it;
        it.nm = $sformatf("step%0d_%s", n_step, st.name());
        it.e  = model(st, mem_ready, zero, funct3_0, op);
        exp_q.push_back(it);
        n_step++;
    endtask

    // One clock cycle: inputs change just after the edge; st is the state expected for this cycle.
    task automatic step(input st_t st, input logic rdy, input logic z, input logic f3, input logic [6:0] o);
        @(posedge clk);
        #1;
        mem_ready = rdy; zero = z; funct3_0 = f3; op = o;
        push(st);
    endtask

    // Changes reset_n between edges; outputs must already be in reset state at the following negedge.
    task automatic reset_edge(input logic val, input logic [6:0] o);
        @(posedge clk);
        #1;
        op = o;
        #1;
        reset_n = val;
        push(T_RESET);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            item_t it;
            outs_t got;
            it  = exp_q.pop_front();
            got = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal_op};
            n_cmp++;
            if (got !== it.e) begin
                n_bad++;
                $display("FAIL %s: got %b required %b (mreq mw adr irw pcw rw rs sa sb aop imm done ill)",
                         it.nm, got, it.e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; op = LW; funct3_0 = 1'b0; zero = 1'b0; mem_ready = 1'b1;

        step(T_RESET, 1, 0, 0, LW);
        step(T_RESET, 1, 0, 0, SW);
        reset_edge(1'b1, LW);

        // lw with two wait cycles in MEMREAD
        step(T_FETCH,   1, 0, 0, LW);
        step(T_DECODE,  1, 0, 0, LW);
        step(T_MEMADR,  1, 0, 0, LW);
        step(T_MEMREAD, 0, 0, 0, LW);
        step(T_MEMREAD, 0, 0, 0, LW);
        step(T_MEMREAD, 1, 0, 0, LW);
        step(T_MEMWB,   1, 0, 0, LW);

        // sw with a fetch stall and a write stall
        step(T_FETCH,    0, 0, 0, SW);
        step(T_FETCH,    1, 0, 0, SW);
        step(T_DECODE,   1, 0, 0, SW);
        step(T_MEMADR,   1, 0, 0, SW);
        step(T_MEMWRITE, 0, 0, 0, SW);
        step(T_MEMWRITE, 1, 0, 0, SW);

        step(T_FETCH,  1, 0, 0, RT);
        step(T_DECODE, 1, 0, 0, RT);
        step(T_EXEC_R, 1, 0, 0, RT);
        step(T_ALUWB,  1, 0, 0, RT);

        step(T_FETCH,  1, 0, 0, IT);
        step(T_DECODE, 0, 0, 0, IT);
        step(T_EXEC_I, 0, 0, 0, IT);
        step(T_ALUWB,  0, 0, 0, IT);

        // beq taken, beq not taken, bne taken, bne not taken
        step(T_FETCH,  1, 1, 0, BR);
        step(T_DECODE, 1, 1, 0, BR);
        step(T_BRANCH, 1, 1, 0, BR);
        step(T_FETCH,  1, 0, 0, BR);
        step(T_DECODE, 1, 0, 0, BR);
        step(T_BRANCH, 1, 0, 0, BR);
        step(T_FETCH,  1, 0, 1, BR);
        step(T_DECODE, 1, 0, 1, BR);
        step(T_BRANCH, 1, 0, 1, BR);
        step(T_FETCH,  1, 1, 1, BR);
        step(T_DECODE, 1, 1, 1, BR);
        step(T_BRANCH, 1, 1, 1, BR);

        step(T_FETCH,  1, 0, 0, JAL);
        step(T_DECODE, 1, 0, 0, JAL);
        step(T_JAL,    1, 0, 0, JAL);
        step(T_ALUWB,  1, 0, 0, JAL);

        step(T_FETCH,   1, 1, 0, JALR);
        step(T_DECODE,  1, 1, 0, JALR);
        step(T_JALR,    1, 1, 0, JALR);
        step(T_JALR_PC, 1, 1, 0, JALR);
        step(T_ALUWB,   1, 1, 0, JALR);

        // reset dropped while a store is waiting on memory
        step(T_FETCH,    1, 0, 0, SW);
        step(T_DECODE,   1, 0, 0, SW);
        step(T_MEMADR,   1, 0, 0, SW);
        step(T_MEMWRITE, 0, 0, 0, SW);
        reset_edge(1'b0, SW);
        step(T_RESET, 1, 0, 0, SW);
        reset_edge(1'b1, RT);
        step(T_FETCH,  1, 0, 0, RT);
        step(T_DECODE, 1, 0, 0, RT);
        step(T_EXEC_R, 1, 0, 0, RT);
        step(T_ALUWB,  1, 0, 0, RT);

        // unsupported opcode traps until reset
        step(T_FETCH,  1, 0, 0, LUI);
        step(T_DECODE, 1, 0, 0, LUI);
        for (int i = 0; i < 10; i++) step(T_TRAP, 1'(i % 2), 1'(i % 3 == 0), 0, LUI);
        reset_edge(1'b0, LUI);
        reset_edge(1'b1, LW);
        step(T_FETCH, 0, 0, 0, LW);
        step(T_FETCH, 1, 0, 0, LW);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
